// File: rtl/sc_psr_condition_unit.sv
// sc_psr_condition_unit: PSR flag latch, one-deep shadow copy for trap
// save/restore, and a Bicc branch-condition evaluator with a req/ack handshake.
module sc_psr_condition_unit #(
  parameter int unsigned COND_WIDTH = 4,
  parameter int unsigned FLAG_WIDTH = 4,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  SC_PSR_CLOCK_50,
  input  logic                  SC_PSR_RESET_InHigh,
  input  logic                  SC_PSR_negative_InLow,
  input  logic                  SC_PSR_zero_InLow,
  input  logic                  SC_PSR_overflow_InLow,
  input  logic                  SC_PSR_carry_InLow,
  input  logic                  SC_PSR_setcc_InLow,
  input  logic                  SC_PSR_load_InHigh,
  input  logic                  SC_PSR_save_InHigh,
  input  logic                  SC_PSR_restore_InHigh,
  input  logic                  SC_PSR_req_InHigh,
  input  logic [COND_WIDTH-1:0] SC_PSR_cond_InBUS,
  output logic                  SC_PSR_ack_OutHigh,
  output logic                  SC_PSR_taken_OutHigh,
  output logic [FLAG_WIDTH-1:0] SC_PSR_flags_OutBUS
);

  // Flag positions within the PSR, order {N,Z,V,C}
  localparam int unsigned BIT_N = 3;
  localparam int unsigned BIT_Z = 2;
  localparam int unsigned BIT_V = 1;
  localparam int unsigned BIT_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [FLAG_WIDTH-1:0] psr;
  logic [FLAG_WIDTH-1:0] shadow;
  logic [FLAG_WIDTH-1:0] newFlags;
  logic [FLAG_WIDTH-1:0] evalFlags;
  logic [COND_WIDTH-1:0] condQ;
  logic                  upd;
  logic                  ack;
  logic                  taken;

  // Bicc: cond[2:0] picks the base predicate, cond[3] inverts it
  function automatic logic bicc(input logic [COND_WIDTH-1:0] c,
                                input logic [FLAG_WIDTH-1:0] f);
    logic n, z, v, cy, base;
    n  = f[BIT_N];
    z  = f[BIT_Z];
    v  = f[BIT_V];
    cy = f[BIT_C];
    unique case (c[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = cy | z;
      3'b101:  base = cy;
      3'b110:  base = n;
      default: base = v;
    endcase
    return c[3] ^ base;
  endfunction

  // Decode the ALU flag interface and pick the flags seen by evaluation
  always_comb begin
    newFlags  = ~{SC_PSR_negative_InLow, SC_PSR_zero_InLow,
                  SC_PSR_overflow_InLow, SC_PSR_carry_InLow};
    upd       = SC_PSR_load_InHigh & ~SC_PSR_setcc_InLow;
    evalFlags = psr;
    if (BYPASS && upd && !SC_PSR_restore_InHigh)
      evalFlags = newFlags;
  end

  // PSR and shadow: restore beats update; save always sees the pre-edge PSR,
  // so save together with restore swaps the two registers
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      psr    <= '0;
      shadow <= '0;
    end else begin
      if (SC_PSR_restore_InHigh)
        psr <= shadow;
      else if (upd)
        psr <= newFlags;
      if (SC_PSR_save_InHigh)
        shadow <= psr;
    end
  end

  // FSM state register
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // FSM next-state: IDLE -> EVAL -> RESP -> IDLE, req only seen in IDLE
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (SC_PSR_req_InHigh) stateNext = EVAL;
      EVAL:    stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture the branch condition alongside an accepted request
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh)
      condQ <= '0;
    else if (state == IDLE && SC_PSR_req_InHigh)
      condQ <= SC_PSR_cond_InBUS;
  end

  // Registered response: ack pulses for the RESP cycle, taken loads on RESP entry
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      ack   <= 1'b0;
      taken <= 1'b0;
    end else begin
      ack <= (state == EVAL);
      if (state == EVAL)
        taken <= bicc(condQ, evalFlags);
    end
  end

  assign SC_PSR_ack_OutHigh   = ack;
  assign SC_PSR_taken_OutHigh = taken;
  assign SC_PSR_flags_OutBUS  = psr;

endmodule
